// File: rtl/seq_chunk_adder.sv
// Sequential chunked adder/subtractor: adds SIZE-bit operands CHUNK bits per clock,
// LSB chunk first, taking SIZE/CHUNK RUN cycles per operation.
// Optional feature: define OVERFLOW_FLAG_EN to build the signed-overflow flag;
// without it, overflow is tied to 0.
module seq_chunk_adder #(
    parameter int unsigned SIZE  = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            carry_In,
    input  logic            sub,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] sum,
    output logic            carry_Out,
    output logic            overflow
);

    localparam int unsigned N    = SIZE / CHUNK;
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

    if ((CHUNK == 0) || ((SIZE % CHUNK) != 0)) begin : g_bad_params
        $error("seq_chunk_adder: SIZE must be a non-zero multiple of CHUNK");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [SIZE-1:0]   a_q, a_d;
    logic [SIZE-1:0]   b_q, b_d;     // already inverted for subtract
    logic              cin_q, cin_d; // effective carry into chunk 0
    logic              carry_q, carry_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [SIZE-1:0]   sum_q, sum_d;
    logic              cout_q, cout_d;

    logic [CHUNK-1:0]  a_chk, b_chk, s_chk;
    logic              c_in_chk, c_out_chk;

`ifdef OVERFLOW_FLAG_EN
    logic              ovf_q, ovf_d;
    logic              c_into_msb;
`endif

    // Chunk datapath: one CHUNK-wide add of the currently indexed slice
    always_comb begin
        a_chk    = a_q[idx_q*CHUNK +: CHUNK];
        b_chk    = b_q[idx_q*CHUNK +: CHUNK];
        // Chunk 0 takes the captured carry-in; later chunks chain the carry register
        c_in_chk = (idx_q == '0) ? cin_q : carry_q;
        {c_out_chk, s_chk} = {1'b0, a_chk} + {1'b0, b_chk} + {{CHUNK{1'b0}}, c_in_chk};
    end

`ifdef OVERFLOW_FLAG_EN
    // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin
    always_comb begin
        c_into_msb = a_chk[CHUNK-1] ^ b_chk[CHUNK-1] ^ s_chk[CHUNK-1];
    end
`endif

    // Next-state logic for the control FSM and datapath registers
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef OVERFLOW_FLAG_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    cin_d   = sub ? 1'b1 : carry_In;
                    carry_d = 1'b0;
                    idx_d   = '0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                sum_d[idx_q*CHUNK +: CHUNK] = s_chk;
                carry_d = c_out_chk;
                if (idx_q == LastIdx) begin
                    idx_d   = '0;
                    cout_d  = c_out_chk;
`ifdef OVERFLOW_FLAG_EN
                    ovf_d   = c_into_msb ^ c_out_chk;
`endif
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

`ifdef OVERFLOW_FLAG_EN
    // Overflow flag register, loaded on the final RUN edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

    // Outputs decoded directly from the registered state
    always_comb begin
        busy      = (state_q == StRun);
        done      = (state_q == StDone);
        sum       = sum_q;
        carry_Out = cout_q;
    end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder (SIZE=32, CHUNK=8): timing, add/sub results,
// flags, start handling during RUN/DONE and asynchronous reset mid-operation.
module tb_seq_chunk_adder;

    localparam int unsigned SIZE = 32;
`ifdef OVERFLOW_FLAG_EN
    localparam logic OvfEn = 1'b1;
`else
    localparam logic OvfEn = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic            start;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic            carry_In;
    logic            sub;
    logic            busy;
    logic            done;
    logic [SIZE-1:0] sum;
    logic            carry_Out;
    logic            overflow;

    int n_cmp;
    int n_err;

    seq_chunk_adder #(
        .SIZE  (SIZE),
        .CHUNK (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .carry_In  (carry_In),
        .sub       (sub),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_Out (carry_Out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, " sum"},  64'(sum),       64'h0);
        check_eq({tag, " cout"}, 64'(carry_Out), 64'h0);
        check_eq({tag, " ovf"},  64'(overflow),  64'h0);
        check_eq({tag, " busy"}, 64'(busy),      64'h0);
        check_eq({tag, " done"}, 64'(done),      64'h0);
    endtask

    // One complete operation with cycle-exact busy/done checks
    task automatic do_op(input string tag, input logic [31:0] opa, input logic [31:0] opb,
                         input logic cin, input logic op_sub, input logic [31:0] exp_sum,
                         input logic exp_cout, input logic exp_ovf);
        @(negedge clk);
        a = opa; b = opb; carry_In = cin; sub = op_sub; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq({tag, " busy run"}, 64'(busy), 64'h1);
            check_eq({tag, " done run"}, 64'(done), 64'h0);
        end
        @(negedge clk);
        check_eq({tag, " done"}, 64'(done),      64'h1);
        check_eq({tag, " busy"}, 64'(busy),      64'h0);
        check_eq({tag, " sum"},  64'(sum),       64'(exp_sum));
        check_eq({tag, " cout"}, 64'(carry_Out), 64'(exp_cout));
        check_eq({tag, " ovf"},  64'(overflow),  64'(exp_ovf));
        @(negedge clk);
        check_eq({tag, " done gone"}, 64'(done),      64'h0);
        check_eq({tag, " sum held"},  64'(sum),       64'(exp_sum));
        check_eq({tag, " cout held"}, 64'(carry_Out), 64'(exp_cout));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0; start = 1'b0; a = '0; b = '0; carry_In = 1'b0; sub = 1'b0;

        // Asynchronous reset before any clock edge
        #2 rst = 1'b1;
        #1 check_idle_outputs("reset async");
        repeat (2) @(negedge clk);
        check_idle_outputs("reset held");
        rst = 1'b0;

        do_op("add wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        do_op("sub 5-7",    32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        do_op("add ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, OvfEn);
        do_op("add cin",    32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0, 32'h2143_6588, 1'b0, 1'b0);
        do_op("sub 7-7",    32'h0000_0007, 32'h0000_0007, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        do_op("sub minneg", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, OvfEn);

        // start during RUN is ignored; start held in DONE chains a second operation
        @(negedge clk);
        a = 32'h1111_1111; b = 32'h2222_2222; carry_In = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check_eq("ignore busy", 64'(busy), 64'h1);
        a = 32'h0000_0100; b = 32'h0000_0001; sub = 1'b1; carry_In = 1'b0; start = 1'b1;
        @(negedge clk);
        check_eq("ignore done", 64'(done),      64'h1);
        check_eq("ignore sum",  64'(sum),       64'h3333_3333);
        check_eq("ignore cout", 64'(carry_Out), 64'h0);
        @(negedge clk);
        start = 1'b0;
        check_eq("chain restart busy", 64'(busy), 64'h1);
        check_eq("chain restart done", 64'(done), 64'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("chain busy", 64'(busy), 64'h1);
            check_eq("chain done", 64'(done), 64'h0);
        end
        @(negedge clk);
        check_eq("chain done pulse", 64'(done),      64'h1);
        check_eq("chain sum",        64'(sum),       64'h0000_00FF);
        check_eq("chain cout",       64'(carry_Out), 64'h1);
        @(negedge clk);
        check_eq("chain done gone",  64'(done),      64'h0);

        // Reset between edges during the second RUN cycle
        do_op("pre rst", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, OvfEn);
        @(negedge clk);
        a = 32'hAAAA_AAAA; b = 32'h1111_1111; carry_In = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_idle_outputs("mid rst");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq("no done after rst", 64'(done), 64'h0);
            check_eq("no busy after rst", 64'(busy), 64'h0);
        end
        do_op("post rst", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_chunk_adder.md
SEQ_CHUNK_ADDER -- requirements
Module: seq_chunk_adder

Interface
- REQ-001 SHALL have parameter SIZE, default 32: operand and result width in bits.
- REQ-002 SHALL have parameter CHUNK, default 8: bits added per clock cycle.
- REQ-003 SHALL port clk, input, 1: single clock; all state updates on the rising edge.
- REQ-004 SHALL port rst, input, 1: reset, asynchronous, active-high.
- REQ-005 SHALL port start, input, 1: request a new operation.
- REQ-006 SHALL port a, input, SIZE: first operand.
- REQ-007 SHALL port b, input, SIZE: second operand.
- REQ-008 SHALL port carry_In, input, 1: carry into bit 0 (add mode only).
- REQ-009 SHALL port sub, input, 1: 0 selects add, 1 selects subtract.
- REQ-010 SHALL port busy, output, 1: high while an operation is in progress.
- REQ-011 SHALL port done, output, 1: one-cycle pulse marking a valid result.
- REQ-012 SHALL port sum, output, SIZE: result.
- REQ-013 SHALL port carry_Out, output, 1: carry out of bit SIZE-1.
- REQ-014 SHALL port overflow, output, 1: signed overflow flag (see Configuration).

Function
- REQ-015 SHALL require SIZE to be an integer multiple of CHUNK, with CHUNK >= 1; N = SIZE/CHUNK.
- REQ-016 SHALL implement states IDLE, RUN and DONE.
- REQ-017 SHALL, in IDLE or DONE with start=1 at a rising edge, capture a, b, sub and the effective carry-in, clear the chunk index and carry register, and enter RUN.
- REQ-018 SHALL use an effective carry-in of carry_In when sub=0; when sub=1 it SHALL replace b with ~b and force the carry-in to 1, ignoring carry_In.
- REQ-019 SHALL, on each RUN edge, add chunk k of a and chunk k of the processed b, plus the carry register, LSB chunk first.
- REQ-020 SHALL, on the same edge, write the CHUNK-bit result into sum[k*CHUNK +: CHUNK] and store the chunk carry-out in the carry register.
- REQ-021 SHALL leave RUN for DONE on the edge that processes chunk N-1; that edge SHALL also load carry_Out with the final carry.
- REQ-022 SHALL assert done in DONE only, for exactly one cycle, so that done is high after the Nth edge following the start edge.
- REQ-023 SHALL drive busy=1 in RUN only.
- REQ-024 SHALL move from DONE to IDLE when start=0, and to RUN (a new capture) when start=1.
- REQ-025 SHALL ignore start while in RUN; operands captured earlier SHALL NOT change.
- REQ-026 SHALL hold sum, carry_Out and overflow stable from DONE through IDLE until the next capture.
- REQ-027 SHALL guarantee sum only while done=1 or in IDLE after a completed operation; sum is undefined-but-deterministic during RUN.
- REQ-028 SHALL compute sum modulo 2^SIZE; in subtract mode, carry_Out=1 SHALL mean no borrow (a >= b unsigned).

Reset
- REQ-029 SHALL, on rst=1 regardless of clock, force the state to IDLE and set sum=0, carry_Out=0, overflow=0, busy=0, done=0, and the chunk index and carry register to 0.
- REQ-030 SHALL abandon an operation when reset arrives mid-RUN; no done pulse SHALL follow, and the next operation SHALL require a fresh start after rst deasserts.

Configuration
- REQ-031 SHALL, with OVERFLOW_FLAG_EN defined, set overflow on the final RUN edge to (carry into bit SIZE-1) XOR (carry out of bit SIZE-1), i.e. signed two's-complement overflow of the operation performed.
- REQ-032 SHALL, without OVERFLOW_FLAG_EN, tie overflow to constant 0 and contain no logic for it; all other behaviour is unchanged.

Verification (SIZE=32, CHUNK=8, N=4)
- REQ-033 SHALL cover: add a=0xFFFFFFFF, b=0x00000001, carry_In=0 -> sum=0x00000000, carry_Out=1, done high for exactly one cycle after the 4th edge following the start edge, busy high for 4 cycles.
- REQ-034 SHALL cover: sub a=5, b=7, carry_In=1 -> sum=0xFFFFFFFE, carry_Out=0, overflow=0.
- REQ-035 SHALL cover: add a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000, carry_Out=0, overflow=1 with OVERFLOW_FLAG_EN and 0 without it.
- REQ-036 SHALL cover: start pulsed again during RUN with different operands -> ignored, first result correct; start held high in DONE -> second operation starts, done pulses again 4 edges later.
- REQ-037 SHALL cover: rst asserted between clock edges during the 2nd RUN cycle -> all outputs 0 immediately, done never pulses, and a subsequent start produces the correct result.
